// File: rtl/irq_ctrl_pkg.sv
// Shared types and constants for the machine-level interrupt controller.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

  localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;
  localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;

  localparam logic [1:0] ADDR_MTIME    = 2'd0;
  localparam logic [1:0] ADDR_MTIMECMP = 2'd1;
  localparam logic [1:0] ADDR_CTRL     = 2'd2;
  localparam logic [1:0] ADDR_STATUS   = 2'd3;

  localparam int unsigned CTRL_TIMER_EN = 0;
  localparam int unsigned CTRL_MTI_EN   = 1;
  localparam int unsigned CTRL_MEI_EN   = 2;

endpackage

// File: rtl/irq_ctrl_if.sv
// Config bus plus trap request/acknowledge handshake between CSR unit and irq_ctrl.
interface irq_ctrl_if;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  logic        irq_ack;
  logic        mret;
  logic        irq_req;
  logic [31:0] cause;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, irq_ack, mret,
    input  cfg_rdata, irq_req, cause
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, irq_ack, mret,
    output cfg_rdata, irq_req, cause
  );
endinterface

// File: rtl/irq_timer.sv
// Machine timer: prescaler, mtime/mtimecmp registers and level compare.
module irq_timer #(
  parameter int unsigned TIMER_W  = 32,
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        timer_en,
  input  logic        wr_mtime,
  input  logic        wr_cmp,
  input  logic [31:0] wdata,
  input  logic        rd_cmp,
  output logic [31:0] rdata,
  output logic        timer_pend
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0]      pcnt;
  logic               tick;
  logic [TIMER_W-1:0] mtime;
  logic [TIMER_W-1:0] mtimecmp;

  assign tick = timer_en && (pcnt == PW'(PRESCALE - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt <= '0;
    end else if (timer_en) begin
      pcnt <= tick ? '0 : pcnt + 1'b1;
    end
  end

  // A software write to mtime takes priority over a coincident increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mtime <= '0;
    end else if (wr_mtime) begin
      mtime <= wdata[TIMER_W-1:0];
    end else if (tick) begin
      mtime <= mtime + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mtimecmp <= '1;
    end else if (wr_cmp) begin
      mtimecmp <= wdata[TIMER_W-1:0];
    end
  end

  assign timer_pend = (mtime >= mtimecmp);
  assign rdata      = rd_cmp ? 32'(mtimecmp) : 32'(mtime);

endmodule

// File: rtl/irq_ctrl.sv
// Machine interrupt controller: ext_irq synchroniser, arbitration and trap FSM.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int unsigned TIMER_W     = 32,
  parameter int unsigned PRESCALE    = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ext_irq,
  input  logic       global_ie,
  irq_ctrl_if.slave  bus
);

  irq_state_e state, state_n;
  logic [31:0] cause_q, cause_n;
  logic [2:0]  ctrl;
  logic [SYNC_STAGES-1:0] sync_q;
  logic        sync_d;
  logic        ext_pend;
  logic        ext_set, ext_clr;
  logic        timer_pend;
  logic [31:0] timer_rdata;
  logic        wr_mtime, wr_cmp, wr_ctrl;
  logic        mei_qual, mti_qual;

  assign wr_mtime = bus.cfg_we && (bus.cfg_addr == ADDR_MTIME);
  assign wr_cmp   = bus.cfg_we && (bus.cfg_addr == ADDR_MTIMECMP);
  assign wr_ctrl  = bus.cfg_we && (bus.cfg_addr == ADDR_CTRL);

  irq_timer #(
    .TIMER_W  (TIMER_W),
    .PRESCALE (PRESCALE)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .timer_en   (ctrl[CTRL_TIMER_EN]),
    .wr_mtime   (wr_mtime),
    .wr_cmp     (wr_cmp),
    .wdata      (bus.cfg_wdata),
    .rd_cmp     (bus.cfg_addr[0]),
    .rdata      (timer_rdata),
    .timer_pend (timer_pend)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl <= '0;
    end else if (wr_ctrl) begin
      ctrl <= bus.cfg_wdata[2:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      sync_d <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ext_irq};
      sync_d <= sync_q[SYNC_STAGES-1];
    end
  end

  // A new edge landing on the acknowledging cycle keeps the event pending.
  assign ext_set = sync_q[SYNC_STAGES-1] && !sync_d;
  assign ext_clr = (state == REQ) && bus.irq_ack && (cause_q == CAUSE_MEI);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ext_pend <= 1'b0;
    end else begin
      ext_pend <= ext_set || (ext_pend && !ext_clr);
    end
  end

  assign mei_qual = ext_pend   && ctrl[CTRL_MEI_EN];
  assign mti_qual = timer_pend && ctrl[CTRL_MTI_EN];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cause_q <= '0;
    end else begin
      state   <= state_n;
      cause_q <= cause_n;
    end
  end

  always_comb begin
    state_n = state;
    cause_n = cause_q;
    unique case (state)
      IDLE: begin
        if (global_ie && mei_qual) begin
          state_n = REQ;
          cause_n = CAUSE_MEI;
        end else if (global_ie && mti_qual) begin
          state_n = REQ;
          cause_n = CAUSE_MTI;
        end
      end
      REQ: begin
        if (bus.irq_ack) begin
          state_n = SERVICE;
          cause_n = '0;
        end
      end
      SERVICE: begin
        if (bus.mret) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        cause_n = '0;
      end
    endcase
  end

  assign bus.irq_req = (state == REQ);
  assign bus.cause   = cause_q;

  always_comb begin
    bus.cfg_rdata = '0;
    unique case (bus.cfg_addr)
      ADDR_MTIME, ADDR_MTIMECMP: bus.cfg_rdata = timer_rdata;
      ADDR_CTRL:                 bus.cfg_rdata = {29'd0, ctrl};
      ADDR_STATUS:               bus.cfg_rdata = {28'd0, state, ext_pend, timer_pend};
      default:                   bus.cfg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl: register table plus trap sequences.
module tb_irq_ctrl;

  localparam logic [31:0] MTI = 32'h8000_0007;
  localparam logic [31:0] MEI = 32'h8000_000B;

  logic clk = 1'b0;
  logic rst;
  logic ext_irq, gie;
  logic ext_irq2, gie2;
  int   checks = 0;
  int   errors = 0;

  irq_ctrl_if bus ();
  irq_ctrl_if bus2 ();

  irq_ctrl #(.TIMER_W(32), .PRESCALE(1), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .ext_irq   (ext_irq),
    .global_ie (gie),
    .bus       (bus)
  );

  irq_ctrl #(.TIMER_W(8), .PRESCALE(2), .SYNC_STAGES(2)) dut2 (
    .clk       (clk),
    .rst       (rst),
    .ext_irq   (ext_irq2),
    .global_ie (gie2),
    .bus       (bus2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [1:0]  rd_addr;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cfg_wr(input bit d2, input logic [1:0] a, input logic [31:0] d);
    if (d2) begin
      bus2.cfg_we = 1'b1; bus2.cfg_addr = a; bus2.cfg_wdata = d;
    end else begin
      bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_wdata = d;
    end
    @(posedge clk); #1;
    bus.cfg_we = 1'b0;
    bus2.cfg_we = 1'b0;
  endtask

  task automatic rd(input bit d2, input logic [1:0] a, output logic [31:0] d);
    if (d2) begin
      bus2.cfg_addr = a; #1 d = bus2.cfg_rdata;
    end else begin
      bus.cfg_addr = a; #1 d = bus.cfg_rdata;
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic pulse_ext();
    ext_irq = 1'b1;
    step();
    ext_irq = 1'b0;
  endtask

  task automatic pulse_ack();
    bus.irq_ack = 1'b1;
    step();
    bus.irq_ack = 1'b0;
  endtask

  task automatic pulse_mret();
    bus.mret = 1'b1;
    step();
    bus.mret = 1'b0;
  endtask

  // Returns the cycle index on which irq_req is first seen, or maxc+1 on timeout.
  task automatic wait_req(input int maxc, output int n);
    n = maxc + 1;
    for (int i = 1; i <= maxc; i++) begin
      step();
      if (bus.irq_req) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    logic [31:0] d;
    int n;
    bit stray;

    tbl[0] = '{2'd2, 32'h0000_0000, 2'd2, 32'h0000_0000};
    tbl[1] = '{2'd1, 32'h1234_5678, 2'd1, 32'h1234_5678};
    tbl[2] = '{2'd0, 32'h0000_0100, 2'd0, 32'h0000_0100};
    tbl[3] = '{2'd2, 32'hFFFF_FFFF, 2'd2, 32'h0000_0007};
    tbl[4] = '{2'd2, 32'h0000_0000, 2'd0, 32'h0000_0101};
    tbl[5] = '{2'd0, 32'h1234_5679, 2'd3, 32'h0000_0001};
    tbl[6] = '{2'd1, 32'hFFFF_FFFF, 2'd3, 32'h0000_0000};
    tbl[7] = '{2'd3, 32'h0000_00FF, 2'd3, 32'h0000_0000};
    tbl[8] = '{2'd2, 32'h0000_0000, 2'd1, 32'hFFFF_FFFF};

    rst = 1'b0; ext_irq = 1'b1; gie = 1'b1; ext_irq2 = 1'b0; gie2 = 1'b0;
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
    bus.irq_ack = 1'b0; bus.mret = 1'b0;
    bus2.cfg_we = 1'b0; bus2.cfg_addr = '0; bus2.cfg_wdata = '0;
    bus2.irq_ack = 1'b0; bus2.mret = 1'b0;

    // Reset held with ext_irq high
    repeat (4) step();
    chk("rst_req", 32'(bus.irq_req), 32'd0);
    chk("rst_cause", bus.cause, 32'd0);
    rd(0, 2'd1, d); chk("rst_mtimecmp", d, 32'hFFFF_FFFF);
    rd(0, 2'd0, d); chk("rst_mtime", d, 32'd0);
    rd(0, 2'd3, d); chk("rst_status", d, 32'd0);
    ext_irq = 1'b0;
    step();
    rst = 1'b1;
    repeat (4) step();
    chk("post_rst_req", 32'(bus.irq_req), 32'd0);

    // Register table with global_ie high but no enables: no trap may appear
    for (int i = 0; i < 9; i++) begin
      cfg_wr(0, tbl[i].addr, tbl[i].wdata);
      rd(0, tbl[i].rd_addr, d);
      chk($sformatf("tbl%0d_rdata", i), d, tbl[i].exp);
      chk($sformatf("tbl%0d_req", i), 32'(bus.irq_req), 32'd0);
    end

    // Timer trap
    cfg_wr(0, 2'd1, 32'd10);
    cfg_wr(0, 2'd0, 32'd0);
    cfg_wr(0, 2'd2, 32'd3);
    wait_req(40, n);
    chk("tmr_latency", 32'(n), 32'd11);
    chk("tmr_cause", bus.cause, MTI);
    rd(0, 2'd0, d); chk("tmr_mtime_at_req", d, 32'd11);
    pulse_ack();
    chk("tmr_ack_req", 32'(bus.irq_req), 32'd0);
    chk("tmr_ack_cause", bus.cause, 32'd0);
    rd(0, 2'd3, d); chk("tmr_service_status", d, 32'h9);
    pulse_mret();
    chk("tmr_mret_req", 32'(bus.irq_req), 32'd0);
    rd(0, 2'd3, d); chk("tmr_mret_status", d, 32'h1);
    wait_req(3, n);
    chk("tmr_rereq", 32'(n), 32'd1);
    chk("tmr_rereq_cause", bus.cause, MTI);
    pulse_ack();
    cfg_wr(0, 2'd1, 32'hFFFF_FFFF);
    pulse_mret();
    repeat (3) step();
    chk("tmr_quiet", 32'(bus.irq_req), 32'd0);

    // External edge
    cfg_wr(0, 2'd2, 32'd4);
    ext_irq = 1'b1;
    wait_req(1, n);
    ext_irq = 1'b0;
    if (n > 1) begin
      wait_req(10, n);
      n = n + 1;
    end
    chk("ext_latency", 32'(n), 32'd4);
    chk("ext_cause", bus.cause, MEI);
    rd(0, 2'd3, d); chk("ext_req_status", d, 32'h6);
    pulse_ack();
    rd(0, 2'd3, d); chk("ext_ack_status", d, 32'h8);
    pulse_mret();

    // Simultaneous: external wins, timer follows
    gie = 1'b0;
    cfg_wr(0, 2'd2, 32'd6);
    cfg_wr(0, 2'd1, 32'd0);
    pulse_ext();
    repeat (4) step();
    rd(0, 2'd3, d); chk("sim_both_pend", d, 32'h3);
    chk("sim_gie0_req", 32'(bus.irq_req), 32'd0);
    gie = 1'b1;
    step();
    chk("sim_req1", 32'(bus.irq_req), 32'd1);
    chk("sim_cause1", bus.cause, MEI);
    pulse_ack();
    rd(0, 2'd3, d); chk("sim_ack1_status", d, 32'h9);
    pulse_mret();
    wait_req(3, n);
    chk("sim_req2", 32'(n), 32'd1);
    chk("sim_cause2", bus.cause, MTI);

    // Hold in REQ: drop gie, remove timer source, mret ignored
    gie = 1'b0;
    cfg_wr(0, 2'd1, 32'hFFFF_FFFF);
    pulse_mret();
    step();
    chk("hold_req", 32'(bus.irq_req), 32'd1);
    chk("hold_cause", bus.cause, MTI);
    rd(0, 2'd3, d); chk("hold_status", d, 32'h4);
    bus.mret = 1'b1;
    pulse_ack();
    bus.mret = 1'b0;
    chk("ackmret_req", 32'(bus.irq_req), 32'd0);
    rd(0, 2'd3, d); chk("ackmret_status", d, 32'h8);

    // External event during SERVICE is held until mret
    gie = 1'b1;
    pulse_ext();
    stray = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus.irq_req) stray = 1'b1;
    end
    chk("svc_no_req", 32'(stray), 32'd0);
    rd(0, 2'd3, d); chk("svc_pend_status", d, 32'hA);
    pulse_ack();
    rd(0, 2'd3, d); chk("svc_ack_ignored", d, 32'hA);
    pulse_mret();
    chk("svc_mret_req", 32'(bus.irq_req), 32'd0);
    wait_req(3, n);
    chk("svc_rereq", 32'(n), 32'd1);
    chk("svc_rereq_cause", bus.cause, MEI);

    // Edge landing on the ack cycle stays pending
    pulse_ext();
    step();
    pulse_ack();
    rd(0, 2'd3, d); chk("coinc_status", d, 32'hA);
    pulse_mret();
    wait_req(3, n);
    chk("coinc_rereq", 32'(n), 32'd1);
    chk("coinc_cause", bus.cause, MEI);
    pulse_ack();
    rd(0, 2'd3, d); chk("coinc_clear_status", d, 32'h8);
    pulse_mret();
    rd(0, 2'd3, d); chk("coinc_idle_status", d, 32'h0);

    // Asynchronous reset while requesting
    pulse_ext();
    wait_req(10, n);
    chk("rstmid_req_before", 32'(bus.irq_req), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("rstmid_req", 32'(bus.irq_req), 32'd0);
    chk("rstmid_cause", bus.cause, 32'd0);
    rd(0, 2'd3, d); chk("rstmid_status", d, 32'd0);
    rd(0, 2'd2, d); chk("rstmid_ctrl", d, 32'd0);
    step();
    rst = 1'b1;
    step();

    // 8-bit timer, prescale 2: wrap drops the level with no request while gie=0
    cfg_wr(1, 2'd0, 32'hABCD_01FE);
    rd(1, 2'd0, d); chk("w8_mtime_trunc", d, 32'h0000_00FE);
    cfg_wr(1, 2'd1, 32'h0000_00FF);
    rd(1, 2'd1, d); chk("w8_mtimecmp", d, 32'h0000_00FF);
    cfg_wr(1, 2'd2, 32'd3);
    step();
    rd(1, 2'd0, d); chk("w8_c1_mtime", d, 32'hFE);
    rd(1, 2'd3, d); chk("w8_c1_status", d, 32'h0);
    step();
    rd(1, 2'd0, d); chk("w8_c2_mtime", d, 32'hFF);
    rd(1, 2'd3, d); chk("w8_c2_status", d, 32'h1);
    step();
    rd(1, 2'd0, d); chk("w8_c3_mtime", d, 32'hFF);
    step();
    rd(1, 2'd0, d); chk("w8_c4_mtime", d, 32'h00);
    rd(1, 2'd3, d); chk("w8_c4_status", d, 32'h0);
    chk("w8_no_req", 32'(bus2.irq_req), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
Machine-level interrupt controller feeding the CSR unit's cause input. Owns a free-running machine timer with compare register and a synchronised external interrupt line. Arbitrates timer vs external requests and presents one stable RISC-V cause word per trap through a req/ack handshake. Blocks new traps until the handler returns via mret.

Parameters:
TIMER_W, 32, width of mtime/mtimecmp counters (8..32)
PRESCALE, 1, clk cycles per mtime increment (>=1)
SYNC_STAGES, 2, flops in ext_irq synchroniser (>=2)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous reset, active-low (0 = reset)
ext_irq  in  1  asynchronous external interrupt line, rising-edge significant
global_ie  in  1  mstatus.MIE from CSR unit
cfg_we  in  1  config write strobe
cfg_addr  in  2  0=mtime, 1=mtimecmp, 2=ctrl, 3=status (RO)
cfg_wdata  in  32  config write data
cfg_rdata  out  32  config read data, combinational from cfg_addr
irq_ack  in  1  CSR unit accepted trap (trap taken into mepc/mcause)
mret  in  1  handler return retired in MW stage
irq_req  out  1  trap request to CSR/pipeline
cause  out  32  RISC-V mcause value, valid while irq_req=1

Behaviour:
- Reset (rst=0, async): mtime=0, mtimecmp=all-ones, ctrl=0, ext_pend=0, sync chain=0, prescale cnt=0, state=IDLE, irq_req=0, cause=0.
- ctrl[0]=timer_en (mtime counts), ctrl[1]=mti_en, ctrl[2]=mei_en; ctrl[31:3] read 0.
- Prescaler: counts 0..PRESCALE-1 while timer_en; mtime increments on terminal count; PRESCALE=1 increments every cycle. Wraps 2^TIMER_W-1 -> 0, no flag.
- cfg write to mtime/mtimecmp takes effect next cycle; write to mtime in same cycle as increment: write wins. Widths: upper 32-TIMER_W bits of writes ignored, reads zero-extend.
- timer_pend = (mtime >= mtimecmp), level, unsigned compare on registered values; cleared only by software raising mtimecmp or lowering mtime.
- ext_irq passes SYNC_STAGES flops; rising edge of synchronised signal sets ext_pend. ext_pend cleared on irq_ack while cause is external. Edge coincident with that ack: set wins (pending kept for next trap).
- status read: bit0=timer_pend, bit1=ext_pend, bit3:2=state encoding.
- Cause encoding: external 32'h8000000B, timer 32'h80000007 (bit31 interrupt, bit3/bit2 distinguish source for CSR decoding).
- FSM:
  IDLE: if global_ie and ((ext_pend and mei_en) or (timer_pend and mti_en)) -> REQ; next cycle irq_req=1, cause latched. Priority: external over timer.
  REQ: irq_req and cause held stable regardless of source/enable changes or global_ie drop; mret ignored. irq_ack -> SERVICE; irq_req=0 and cause=0 the cycle after ack.
  SERVICE: no new request; pending events continue to accumulate. mret -> IDLE. irq_ack here ignored.
- Request latency: 1 cycle from qualified pending (registered) to irq_req; ext_irq pin-to-irq_req = SYNC_STAGES+2 cycles.
- mret and irq_ack same cycle in REQ: ack honoured, mret ignored.
- Reset mid-REQ/SERVICE: immediate return to reset values; pending lost.

Decomposition:
- Package irq_pkg: state enum (IDLE, REQ, SERVICE), cause constants CAUSE_MTI=32'h80000007, CAUSE_MEI=32'h8000000B, cfg address constants, ctrl bit indices.
- Sub-module irq_timer: prescaler, mtime, mtimecmp, timer_pend compare, config write/read of its two registers. FSM, synchroniser and arbitration stay in top.

Test Plan:
- Reset: hold rst=0 with ext_irq=1 -> irq_req=0, cause=0, cfg_rdata(addr1)=32'hFFFFFFFF; release -> no request until enables set.
- Timer trap: PRESCALE=1, ctrl=3'b011, mtimecmp=10, global_ie=1 -> irq_req rises when mtime=10 plus 1 cycle, cause=32'h80000007; ack -> irq_req=0 next cycle; mret with mtimecmp still 10 -> re-request immediately.
- External edge: ctrl=3'b100, pulse ext_irq 1 cycle -> irq_req after SYNC_STAGES+2 cycles, cause=32'h8000000B; ack clears ext_pend (status bit1=0).
- Simultaneous: timer_pend and ext_pend both set -> external first; after ack+mret, timer trap with 32'h80000007.
- Hold/ignore: in REQ drop global_ie and raise mtimecmp -> irq_req/cause unchanged until ack; mret during REQ no effect; new ext edge during SERVICE held and requested right after mret.
- Wrap: TIMER_W=8, mtime=8'hFE, mtimecmp=8'hFF -> pend at FF, mtime wraps to 00 and pend drops (status bit0=0) with no spurious request if not yet taken while global_ie=0.
